// File: rtl/approx_mult_pkg.sv
// Shared types and widths for the approximate-multiplier error evaluator.
// The widths here are fixed for the 8-bit operand family; the top-level W
// parameter is expected to match W_PKG.
package approx_mult_pkg;

    localparam int W_PKG = 8;
    localparam int PW    = 2 * W_PKG;   // product width
    localparam int ACC_W = 4 * W_PKG;   // accumulator width

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } eval_state_t;

    typedef struct packed {
        logic [PW:0]      err_count;       // up to 2^PW mismatching pairs
        logic [ACC_W-1:0] sum_abs_err;
        logic [PW-1:0]    max_abs_err;
        logic [ACC_W:0]   sum_signed_err;  // two's complement
    } err_metrics_t;

endpackage

// File: rtl/err_accum.sv
// Compare and accumulate stages of the error evaluator.
//   clk, rst   : clock, synchronous active-high reset
//   clr        : clears all metrics (start of a new sweep)
//   valid      : z/exact pair is a real sample this cycle
//   z, exact   : approximate and exact products, already aligned
//   cmp_vld    : compare stage holds a valid entry (used for drain detection)
//   metrics    : live error metrics
module err_accum
    import approx_mult_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          valid,
    input  logic [PW-1:0] z,
    input  logic [PW-1:0] exact,
    output logic          cmp_vld,
    output err_metrics_t  metrics
);

    logic          cmp_vld_q, cmp_vld_d;
    logic [PW:0]   err_q, err_d;
    logic [PW-1:0] abs_q, abs_d;
    logic [PW:0]   neg_err;
    err_metrics_t  metrics_q, metrics_d;

    always_comb begin
        // One extra bit keeps z - exact exact as a signed value.
        err_d     = {1'b0, z} - {1'b0, exact};
        neg_err   = ~err_d + 1'b1;
        abs_d     = err_d[PW] ? neg_err[PW-1:0] : err_d[PW-1:0];
        cmp_vld_d = valid;

        metrics_d = metrics_q;
        if (clr) begin
            metrics_d = '0;
        end else if (cmp_vld_q) begin
            metrics_d.err_count      = metrics_q.err_count + {{PW{1'b0}}, |abs_q};
            metrics_d.sum_abs_err    = metrics_q.sum_abs_err + {{(ACC_W-PW){1'b0}}, abs_q};
            if (abs_q > metrics_q.max_abs_err)
                metrics_d.max_abs_err = abs_q;
            metrics_d.sum_signed_err = metrics_q.sum_signed_err + {{(ACC_W-PW){err_q[PW]}}, err_q};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmp_vld_q <= 1'b0;
            err_q     <= '0;
            abs_q     <= '0;
            metrics_q <= '0;
        end else begin
            cmp_vld_q <= cmp_vld_d;
            err_q     <= err_d;
            abs_q     <= abs_d;
            metrics_q <= metrics_d;
        end
    end

    assign cmp_vld = cmp_vld_q;
    assign metrics = metrics_q;

endmodule

// File: rtl/approx_mult_err_eval.sv
// Exhaustive error characterisation of an 8x8 approximate multiplier.
// Sweeps every (x, y) pair, aligns the exact product with the multiplier
// output through a delay line, and accumulates error metrics.
//   clk, rst        : clock, synchronous active-high reset
//   start           : pulse; begins a sweep from IDLE or DONE
//   busy, done      : status (busy in SWEEP/DRAIN, done held in DONE)
//   mult_x, mult_y  : operands to the multiplier under test
//   mult_z          : product, valid MULT_LAT cycles after the operands
//   err_count, sum_abs_err, max_abs_err, sum_signed_err : metrics
module approx_mult_err_eval
    import approx_mult_pkg::*;
#(
    parameter int W        = 8,
    parameter int MULT_LAT = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    output logic           busy,
    output logic           done,
    output logic [W-1:0]   mult_x,
    output logic [W-1:0]   mult_y,
    input  logic [2*W-1:0] mult_z,
    output logic [2*W:0]   err_count,
    output logic [4*W-1:0] sum_abs_err,
    output logic [2*W-1:0] max_abs_err,
    output logic [4*W:0]   sum_signed_err
);

    localparam int P = 2 * W;

    eval_state_t state_q, state_d;
    logic [P-1:0]  cnt_q, cnt_d;
    logic [W-1:0]  mult_x_q, mult_x_d, mult_y_q, mult_y_d;
    logic          busy_q, busy_d, done_q, done_d;
    logic [MULT_LAT:0]        vld_pipe_q, vld_pipe_d;
    logic [MULT_LAT:0][P-1:0] exact_pipe_q, exact_pipe_d;
    logic          clr;
    logic          cmp_vld;
    err_metrics_t  metrics;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr     = 1'b0;
        case (state_q)
            IDLE, DONE: if (start) begin
                state_d = SWEEP;
                cnt_d   = '0;
                clr     = 1'b1;
            end
            SWEEP: begin
                // Natural wrap leaves cnt at 0 on entry to DRAIN.
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == '1)
                    state_d = DRAIN;
            end
            DRAIN: if (!(|vld_pipe_q) && !cmp_vld)
                state_d = DONE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == SWEEP) || (state_d == DRAIN);
        done_d = (state_d == DONE);

        // Operands are registered together with stage 0 of the delay line,
        // so stage MULT_LAT lines up with mult_z.
        mult_x_d        = cnt_q[P-1:W];
        mult_y_d        = cnt_q[W-1:0];
        vld_pipe_d[0]   = (state_q == SWEEP);
        exact_pipe_d[0] = {{W{1'b0}}, cnt_q[P-1:W]} * {{W{1'b0}}, cnt_q[W-1:0]};
        for (int i = 1; i <= MULT_LAT; i++) begin
            vld_pipe_d[i]   = vld_pipe_q[i-1];
            exact_pipe_d[i] = exact_pipe_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            mult_x_q     <= '0;
            mult_y_q     <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            vld_pipe_q   <= '0;
            exact_pipe_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mult_x_q     <= mult_x_d;
            mult_y_q     <= mult_y_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            vld_pipe_q   <= vld_pipe_d;
            exact_pipe_q <= exact_pipe_d;
        end
    end

    err_accum u_err_accum (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .valid   (vld_pipe_q[MULT_LAT]),
        .z       (mult_z),
        .exact   (exact_pipe_q[MULT_LAT]),
        .cmp_vld (cmp_vld),
        .metrics (metrics)
    );

    assign busy           = busy_q;
    assign done           = done_q;
    assign mult_x         = mult_x_q;
    assign mult_y         = mult_y_q;
    assign err_count      = metrics.err_count;
    assign sum_abs_err    = metrics.sum_abs_err;
    assign max_abs_err    = metrics.max_abs_err;
    assign sum_signed_err = metrics.sum_signed_err;

endmodule

// File: tb/tb_approx_mult_err_eval.sv
// Four evaluators run in lockstep on shared clk/rst/start:
//   0: exact multiplier, MULT_LAT=0
//   1: constant-zero multiplier, MULT_LAT=0
//   2: LSB stuck-at-1 multiplier, MULT_LAT=0
//   3: exact multiplier registered twice, MULT_LAT=2
module tb_approx_mult_err_eval;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start;
    logic        busy [4];
    logic        done [4];
    logic [7:0]  mx   [4];
    logic [7:0]  my   [4];
    logic [15:0] z    [4];
    logic [16:0] ec   [4];
    logic [31:0] sa   [4];
    logic [15:0] ma   [4];
    logic [32:0] ss   [4];
    logic [15:0] r1 = '0, r2 = '0;

    assign z[0] = {8'd0, mx[0]} * {8'd0, my[0]};
    assign z[1] = 16'd0;
    assign z[2] = ({8'd0, mx[2]} * {8'd0, my[2]}) | 16'd1;
    assign z[3] = r2;

    always @(posedge clk) begin
        r1 <= {8'd0, mx[3]} * {8'd0, my[3]};
        r2 <= r1;
    end

    for (genvar g = 0; g < 4; g++) begin : g_dut
        approx_mult_err_eval #(.W(8), .MULT_LAT((g == 3) ? 2 : 0)) u_dut (
            .clk            (clk),
            .rst            (rst),
            .start          (start),
            .busy           (busy[g]),
            .done           (done[g]),
            .mult_x         (mx[g]),
            .mult_y         (my[g]),
            .mult_z         (z[g]),
            .err_count      (ec[g]),
            .sum_abs_err    (sa[g]),
            .max_abs_err    (ma[g]),
            .sum_signed_err (ss[g])
        );
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int k, da, dd;
        rst = 1'b1; start = 1'b0;
        step(3);
        chk("rst_busy", busy[2], 0);
        chk("rst_done", done[2], 0);
        chk("rst_mult", {mx[2], my[2]}, 0);
        chk("rst_ec",   ec[2], 0);
        chk("rst_ss",   $signed(ss[2]), 0);
        rst = 1'b0;
        step(1);

        // Short sweep, then abort with reset.
        start = 1'b1; step(1); start = 1'b0;
        chk("start_busy", busy[2], 1);
        chk("start_done", done[2], 0);
        chk("start_ec",   ec[2], 0);
        step(20);
        // Pairs 0..17 (x=0) accumulated, each off by exactly +1.
        chk("early_ec",   ec[2], 18);
        chk("early_sa",   sa[2], 18);
        chk("early_ma",   ma[2], 1);
        chk("early_ss",   $signed(ss[2]), 18);
        chk("early_mult", {mx[2], my[2]}, 19);
        rst = 1'b1; step(1); rst = 1'b0;
        chk("abort_busy", busy[2], 0);
        chk("abort_done", done[2], 0);
        chk("abort_ec",   ec[2], 0);
        chk("abort_sa",   sa[2], 0);
        chk("abort_ma",   ma[2], 0);
        chk("abort_ss",   $signed(ss[2]), 0);
        chk("abort_mult", {mx[2], my[2]}, 0);
        step(2);
        chk("idle_busy", busy[2], 0);

        // Full sweep.
        start = 1'b1; step(1); start = 1'b0;
        k = 0;
        step(1000); k = 1000;
        start = 1'b1; step(1); start = 1'b0; k = 1001;
        chk("ign_mult", {mx[0], my[0]}, 1000);
        chk("ign_busy", busy[0], 1);
        // Pairs 0..998: 256 + 128 + 256 + 116 even products.
        chk("ign_ec", ec[2], 756);
        chk("ign_ss", $signed(ss[2]), 756);

        da = 0; dd = 0;
        while (dd == 0 && k < 66000) begin
            step(1); k++;
            if (k == 65536) begin
                chk("last_pair",  {mx[0], my[0]}, 16'hFFFF);
                chk("drain_busy", busy[0], 1);
                chk("drain_done", done[0], 0);
            end
            if (k == 65537) chk("wrap_mult", {mx[0], my[0]}, 0);
            if (da == 0 && done[0]) da = k;
            if (dd == 0 && done[3]) dd = k;
        end
        chk("lat0_done_cycles", da, 65539);
        chk("lat2_done_cycles", dd, 65541);
        chk("done_busy", busy[0], 0);

        chk("exact_ec", ec[0], 0);
        chk("exact_sa", sa[0], 0);
        chk("exact_ma", ma[0], 0);
        chk("exact_ss", $signed(ss[0]), 0);
        chk("zero_ec",  ec[1], 65025);
        chk("zero_sa",  sa[1], 1065369600);
        chk("zero_ma",  ma[1], 65025);
        chk("zero_ss",  $signed(ss[1]), -64'sd1065369600);
        chk("lsb_ec",   ec[2], 49152);
        chk("lsb_sa",   sa[2], 49152);
        chk("lsb_ma",   ma[2], 1);
        chk("lsb_ss",   $signed(ss[2]), 49152);
        chk("lat2_ec",  ec[3], 0);
        chk("lat2_sa",  sa[3], 0);
        chk("lat2_ma",  ma[3], 0);
        chk("lat2_ss",  $signed(ss[3]), 0);

        step(5);
        chk("done_held", done[0], 1);

        // Restart from DONE clears metrics and sweeps again.
        start = 1'b1; step(1); start = 1'b0;
        chk("restart_done", done[2], 0);
        chk("restart_busy", busy[2], 1);
        chk("restart_ec",   ec[2], 0);
        chk("restart_sa_z", sa[1], 0);
        chk("restart_ma_z", ma[1], 0);
        step(20);
        chk("restart_ec20", ec[2], 18);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/approx_mult_err_eval.md
Name: approx_mult_err_eval

Overview:
- Exhaustive error-characterisation engine for 8x8 unsigned approximate multipliers (exchange/truncated variants, l=6 family).
- Sits directly upstream of the multiplier under test: generates every (x, y) operand pair, feeds the multiplier, consumes its 16-bit product z, and compares it against the exact product.
- Accumulates error rate, sum of absolute error, max absolute error and signed bias; the results feed the lambda/fval ranking flow.

Parameters:
- W, 8, operand width; product width is 2*W.
- MULT_LAT, 0, pipeline latency of the attached multiplier in cycles (0 = combinational).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- start  in  1  one-cycle pulse; begins a sweep when IDLE or DONE
- busy  out  1  high in SWEEP and DRAIN
- done  out  1  high in DONE; held until the next start or rst
- mult_x  out  W  operand x to the multiplier under test
- mult_y  out  W  operand y to the multiplier under test
- mult_z  in  2W  product from the multiplier, valid MULT_LAT cycles after mult_x/mult_y
- err_count  out  2W+1  number of pairs with z != x*y (max 65536)
- sum_abs_err  out  4W  sum of |z - x*y|
- max_abs_err  out  2W  largest |z - x*y|
- sum_signed_err  out  4W+1  two's-complement sum of (z - x*y)

Behaviour:
- Reset: state IDLE. mult_x, mult_y, every metric, busy, done and the whole pipeline clear to 0. Reset mid-sweep aborts immediately and nothing is retained.
- FSM: IDLE -start-> SWEEP; SWEEP -last pair issued-> DRAIN; DRAIN -pipeline empty-> DONE; DONE -start-> SWEEP.
- start in IDLE or DONE clears all metrics in the same cycle. start in SWEEP or DRAIN is ignored.
- Operand counter cnt is 2W bits: mult_x = cnt[2W-1:W], mult_y = cnt[W-1:0].
- SWEEP issues one pair per cycle, from 0 to 2^(2W)-1 (65536 cycles). The counter wraps to 0 on entering DRAIN.
- Issue pipeline: each cycle a registered valid bit and exact product x*y enter a delay line. Depth is MULT_LAT+1, so the exact product is aligned with mult_z.
- Compare stage (registered): err = z - exact, computed as a 2W+1-bit signed value, and abs_err = |err|.
- Accumulate stage (next cycle), when valid:
  - err_count increments if abs_err != 0.
  - sum_abs_err += abs_err.
  - max_abs_err = max(max_abs_err, abs_err).
  - sum_signed_err += sign-extended err.
- Width rules: for W=8 the worst case is 65536*65025 < 2^32, so no saturation logic is needed. Sums are sized to be exact.
- Total latency from the first issue to done is 2^(2W) + MULT_LAT + 3 cycles. DRAIN exits when the delay line and the compare stage hold no valid entries.
- Metric outputs update live during the sweep and are final only while done=1.
- A start arriving in the same cycle as the DRAIN->DONE transition is ignored.

Decomposition:
- Shared package approx_mult_pkg holds:
  - localparam widths: PW = 2W, ACC_W = 4W;
  - state enum eval_state_t {IDLE, SWEEP, DRAIN, DONE};
  - the metric struct err_metrics_t.
- One sub-module, err_accum: compare and accumulate stages. It takes valid, z, exact and clr, and outputs the four metrics.
- The top level contains the FSM, the operand counter and the delay line.

Test Plan:
- Exact loopback (mult_z = x*y), MULT_LAT=0 -> done after 65539 cycles; err_count=0, sum_abs_err=0, max_abs_err=0, sum_signed_err=0.
- Constant-zero multiplier (mult_z=0) -> err_count=65025, sum_abs_err=1065369600, max_abs_err=65025, sum_signed_err=-1065369600.
- LSB stuck-at-1 (mult_z = x*y | 1) -> err_count=49152, sum_abs_err=49152, max_abs_err=1, sum_signed_err=+49152.
- MULT_LAT=2 with a registered exact multiplier -> all metrics 0; done after 65541 cycles, proving alignment.
- rst asserted at cycle 30000 of SWEEP -> next cycle: IDLE, busy=0, done=0, all metrics 0. A following start produces a full correct sweep.
- start pulsed during SWEEP and again in DONE -> the first is ignored (count unchanged). The second clears the metrics and restarts, giving identical final results.
